branch_predict_btb: RTL

//  Direct-mapped BTB with 2-bit saturating counters. Predicts next PC in IF; resolves branches/jumps in ID

---
 rtl/branch_predict_btb.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/branch_predict_btb.sv
// Direct-mapped branch target buffer with 2-bit saturating counters: IF-stage lookup, ID-stage resolve/redirect.
// Optional performance counters are enabled with `define BTB_PERF_CNT_EN.
module branch_predict_btb #(
  parameter int IDX_W = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] if_pc,
  output logic        if_pred_taken,
  output logic [31:0] if_pred_target,
  input  logic        id_valid,
  input  logic        id_stall,
  input  logic        id_br,
  input  logic        id_jump,
  input  logic [31:0] id_pc,
  input  logic [31:0] id_target,
  input  logic        cmp_c,
  input  logic        id_pred_taken,
  input  logic [31:0] id_pred_target,
  output logic        redirect,
  output logic [31:0] redirect_pc,
  output logic [31:0] perf_br_cnt,
  output logic [31:0] perf_miss_cnt
);

  localparam int ENTRIES = 1 << IDX_W;
  localparam int TAG_W   = 32 - IDX_W - 2;

  logic [ENTRIES-1:0] valid_q;
  logic [TAG_W-1:0]   tag_q    [ENTRIES];
  logic [31:0]        target_q [ENTRIES];
  logic [1:0]         ctr_q    [ENTRIES];

  // pc[1:0] never participates in indexing or tagging
  logic unused_pc_bits;
  assign unused_pc_bits = ^{if_pc[1:0], id_pc[1:0]};

  // IF lookup
  logic [IDX_W-1:0] if_idx;
  logic [TAG_W-1:0] if_tag;
  logic             if_hit;

  assign if_idx = if_pc[IDX_W+1:2];
  assign if_tag = if_pc[31:IDX_W+2];
  assign if_hit = valid_q[if_idx] && (tag_q[if_idx] == if_tag);

  always_comb begin
    if_pred_taken  = 1'b0;
    if_pred_target = if_pc + 32'd4;
    if (!rst && if_hit) begin
      if_pred_taken  = ctr_q[if_idx][1];
      if_pred_target = target_q[if_idx];
    end
  end

  // ID resolve
  logic             resolve;
  logic             is_br;
  logic             actual_taken;
  logic [IDX_W-1:0] id_idx;
  logic [TAG_W-1:0] id_tag;
  logic             id_hit;

  assign resolve      = id_valid & ~id_stall & (id_br | id_jump);
  assign is_br        = id_br & ~id_jump;
  assign actual_taken = id_jump | (id_br & cmp_c);
  assign id_idx       = id_pc[IDX_W+1:2];
  assign id_tag       = id_pc[31:IDX_W+2];
  assign id_hit       = valid_q[id_idx] && (tag_q[id_idx] == id_tag);

  always_comb begin
    redirect    = 1'b0;
    redirect_pc = actual_taken ? id_target : (id_pc + 32'd4);
    if (!rst && resolve) begin
      redirect = (actual_taken != id_pred_taken) ||
                 (actual_taken && id_pred_taken && (id_pred_target != id_target));
    end
  end

  // Table update decision: upd_fill rewrites valid/tag/target, upd_en rewrites the counter
  logic       upd_en;
  logic       upd_fill;
  logic [1:0] upd_ctr;

  always_comb begin
    upd_en   = 1'b0;
    upd_fill = 1'b0;
    upd_ctr  = ctr_q[id_idx];
    if (resolve) begin
      if (!is_br) begin
        upd_en   = 1'b1;
        upd_fill = 1'b1;
        upd_ctr  = 2'b11;
      end else if (id_hit) begin
        upd_en   = 1'b1;
        upd_fill = actual_taken;
        if (actual_taken) begin
          upd_ctr = (ctr_q[id_idx] == 2'b11) ? 2'b11 : ctr_q[id_idx] + 2'd1;
        end else begin
          upd_ctr = (ctr_q[id_idx] == 2'b00) ? 2'b00 : ctr_q[id_idx] - 2'd1;
        end
      end else if (actual_taken) begin
        upd_en   = 1'b1;
        upd_fill = 1'b1;
        upd_ctr  = 2'b10;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        ctr_q[i] <= 2'b01;
      end
    end else if (upd_en) begin
      ctr_q[id_idx] <= upd_ctr;
      if (upd_fill) begin
        valid_q[id_idx]  <= 1'b1;
        tag_q[id_idx]    <= id_tag;
        target_q[id_idx] <= id_target;
      end
    end
  end

`ifdef BTB_PERF_CNT_EN
  logic [31:0] br_cnt_q;
  logic [31:0] miss_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      br_cnt_q   <= '0;
      miss_cnt_q <= '0;
    end else begin
      if (resolve)  br_cnt_q   <= br_cnt_q + 32'd1;
      if (redirect) miss_cnt_q <= miss_cnt_q + 32'd1;
    end
  end

  assign perf_br_cnt   = br_cnt_q;
  assign perf_miss_cnt = miss_cnt_q;
`else
  assign perf_br_cnt   = 32'h0;
  assign perf_miss_cnt = 32'h0;
`endif

endmodule
